// File: rtl/dmem_responder.sv
// Handshaked data-memory responder for the core's load/store path.
// One request is accepted at a time from IDLE. After LATENCY wait cycles the access runs on a
// word-organised RAM, and the result is held on the response channel until it is taken.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_wr, req_op        store flag, MemOp (byte/half/word, signed/unsigned)
//   req_addr, req_wdata   byte address, right-aligned store data
//   resp_valid/resp_ready response handshake (valid only in RESP)
//   resp_rdata, resp_err  extended load data (0 for stores/errors), access error flag
module dmem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h80000000,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [2:0]      op_q, op_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            exec;
  logic            mem_we;

  logic [31:0]     mem_q [DEPTH];

  // Access decode. With LATENCY=0 the access runs on the accept edge, so it must use the live
  // request; otherwise it runs from the latched copy.
  logic        a_wr;
  logic [2:0]  a_op;
  logic [31:0] a_addr, a_wdata;
  logic [31:2] a_woff;
  logic [AW-1:0] a_idx;
  logic        a_err;
  logic [31:0] rword, ld_data, st_word, be_mask, wd_rep;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    a_wr    = (state_q == StIdle) ? req_wr    : wr_q;
    a_op    = (state_q == StIdle) ? req_op    : op_q;
    a_addr  = (state_q == StIdle) ? req_addr  : addr_q;
    a_wdata = (state_q == StIdle) ? req_wdata : wdata_q;
    // BASE is word aligned, so the word offset is a subtraction of the upper bits only.
    a_woff  = a_addr[31:2] - BASE[31:2];
    a_idx   = a_woff[AW+1:2];
    rword   = mem_q[a_idx];

    a_err = 1'b0;
    if (a_addr < BASE) a_err = 1'b1;
    if ({2'b00, a_woff} >= DEPTH) a_err = 1'b1;
    case (a_op)
      3'b000, 3'b100: ;
      3'b001, 3'b101: if (a_addr[0]) a_err = 1'b1;
      3'b010:         if (a_addr[1:0] != 2'b00) a_err = 1'b1;
      default:        a_err = 1'b1;
    endcase
    if (a_wr && a_op[2]) a_err = 1'b1;

    byte_v = 8'(rword >> {a_addr[1:0], 3'b000});
    half_v = a_addr[1] ? rword[31:16] : rword[15:0];
    case (a_op)
      3'b000:  ld_data = {{24{byte_v[7]}}, byte_v};
      3'b100:  ld_data = {24'h0, byte_v};
      3'b001:  ld_data = {{16{half_v[15]}}, half_v};
      3'b101:  ld_data = {16'h0, half_v};
      default: ld_data = rword;
    endcase

    // Replicate store data across lanes, then merge only the addressed lanes into the word.
    case (a_op[1:0])
      2'b00: begin
        be_mask = 32'h0000_00ff << {a_addr[1:0], 3'b000};
        wd_rep  = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        be_mask = 32'h0000_ffff << {a_addr[1], 4'b0000};
        wd_rep  = {2{a_wdata[15:0]}};
      end
      default: begin
        be_mask = 32'hffff_ffff;
        wd_rep  = a_wdata;
      end
    endcase
    st_word = (rword & ~be_mask) | (wd_rep & be_mask);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      op_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM contents survive reset; a write on a reset edge is dropped so a pending store is lost.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[a_idx] <= st_word;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    exec    = 1'b0;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          wr_d    = req_wr;
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY == 0) begin
            exec    = 1'b1;
            state_d = StResp;
          end else begin
            cnt_d   = CntW'(LATENCY - 1);
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          exec    = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (exec) begin
      err_d   = a_err;
      rdata_d = (a_err || a_wr) ? 32'h0 : ld_data;
    end
    mem_we = exec && a_wr && !a_err && !rst;
  end

  // Outputs.
  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = (state_q == StResp);
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end

endmodule
